// File: rtl/yarp_pkg.sv
// Shared types for the load/store unit.
//   lsu_size_t  : access size encoding as it arrives from decode (11 is treated as WORD)
//   lsu_state_t : load/store FSM states
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus handshake bundle between the load/store unit and the memory side.
//   master : LSU side, drives request/address/enables/write data, receives grant/response
//   slave  : memory side, the mirror image
interface load_store_unit_if;

  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  modport master (
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   size/offset/zero_extnd : access size, addr[1:0], load extension mode
//   wr_data -> wr_data_rep : store data replicated across the lanes it may land in
//   byte_en                : byte enables for the addressed lanes
//   rd_data_raw -> rd_data_ext : bus word right-aligned and sign/zero-extended
//   misaligned             : HALF on an odd address or WORD not on a word boundary
module lsu_align
  import yarp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zero_extnd,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_data_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data_rep,
  output logic [31:0] rd_data_ext,
  output logic        misaligned
);

  lsu_size_t   sz;
  logic [31:0] shifted;

  assign sz      = lsu_size_t'(size);
  assign shifted = rd_data_raw >> {offset, 3'b000};

  // Defaults describe a WORD access, which also covers the unused 11 encoding.
  always_comb begin
    byte_en     = 4'b1111;
    wr_data_rep = wr_data;
    rd_data_ext = shifted;
    misaligned  = (offset != 2'b00);
    case (sz)
      BYTE: begin
        byte_en     = 4'b0001 << offset;
        wr_data_rep = {4{wr_data[7:0]}};
        rd_data_ext = zero_extnd ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
        misaligned  = 1'b0;
      end
      HALF: begin
        byte_en     = 4'b0011 << offset;
        wr_data_rep = {2{wr_data[15:0]}};
        rd_data_ext = zero_extnd ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        misaligned  = offset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sits between execute and the external data bus.
//   clk, reset_n        : clock, asynchronous active-low reset
//   lsu_* inputs        : request from execute, held stable while lsu_stall_o is high
//   lsu_stall_o         : combinational stall back to the core
//   lsu_done_o etc.     : one-cycle completion pulse with load data and error flags
//   bus (master)        : request/grant/response data bus
module load_store_unit
  import yarp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lsu_req_i,
  input  logic        lsu_wr_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wr_data_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zero_extnd_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rd_data_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_err_o,
  load_store_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data_rep;
  logic [31:0]      rd_data_ext;
  logic             misaligned;

  // Read-side alignment uses the live lsu inputs: the core holds them
  // stable for the whole access because it is stalled.
  lsu_align u_align (
    .size        (lsu_size_i),
    .offset      (lsu_addr_i[1:0]),
    .zero_extnd  (lsu_zero_extnd_i),
    .wr_data     (lsu_wr_data_i),
    .rd_data_raw (bus.bus_rdata_i),
    .byte_en     (byte_en),
    .wr_data_rep (wr_data_rep),
    .rd_data_ext (rd_data_ext),
    .misaligned  (misaligned)
  );

  // Released in the DONE cycle so the core advances at the end of it.
  assign lsu_stall_o = lsu_req_i & (state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      bus.bus_req_o    <= 1'b0;
      bus.bus_addr_o   <= '0;
      bus.bus_we_o     <= 1'b0;
      bus.bus_be_o     <= '0;
      bus.bus_wdata_o  <= '0;
      lsu_done_o       <= 1'b0;
      lsu_rd_data_o    <= '0;
      lsu_misaligned_o <= 1'b0;
      lsu_err_o        <= 1'b0;
    end else begin
      lsu_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            if (misaligned) begin
              state            <= DONE;
              lsu_done_o       <= 1'b1;
              lsu_misaligned_o <= 1'b1;
              lsu_err_o        <= 1'b0;
              lsu_rd_data_o    <= '0;
            end else begin
              state           <= REQ;
              bus.bus_req_o   <= 1'b1;
              bus.bus_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              bus.bus_we_o    <= lsu_wr_i;
              bus.bus_be_o    <= byte_en;
              bus.bus_wdata_o <= wr_data_rep;
            end
          end
        end
        // A response arriving before the grant is not ours and is ignored.
        REQ: begin
          if (bus.bus_gnt_i) begin
            state         <= WAIT;
            bus.bus_req_o <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        WAIT: begin
          if (bus.bus_rvalid_i) begin
            state            <= DONE;
            lsu_done_o       <= 1'b1;
            lsu_misaligned_o <= 1'b0;
            lsu_err_o        <= bus.bus_err_i;
            lsu_rd_data_o    <= bus.bus_we_o ? 32'h0 : rd_data_ext;
          end else if (wait_cnt == CNT_MAX) begin
            state            <= DONE;
            lsu_done_o       <= 1'b1;
            lsu_misaligned_o <= 1'b0;
            lsu_err_o        <= 1'b1;
            lsu_rd_data_o    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout shortened to 4 cycles).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lsu_req_i;
  logic        lsu_wr_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wr_data_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_zero_extnd_i;
  logic        lsu_stall_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rd_data_o;
  logic        lsu_misaligned_o;
  logic        lsu_err_o;

  int total = 0;
  int bad   = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .lsu_req_i        (lsu_req_i),
    .lsu_wr_i         (lsu_wr_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wr_data_i    (lsu_wr_data_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_zero_extnd_i (lsu_zero_extnd_i),
    .lsu_stall_o      (lsu_stall_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_rd_data_o    (lsu_rd_data_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .lsu_err_o        (lsu_err_o),
    .bus              (bus_if)
  );

  always #5 clk = ~clk;

  // Moves to 2 time units after the next rising edge; registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] size, input logic zext);
    lsu_req_i        = req;
    lsu_wr_i         = wr;
    lsu_addr_i       = addr;
    lsu_wr_data_i    = wd;
    lsu_size_i       = size;
    lsu_zero_extnd_i = zext;
  endtask

  task automatic applyBusResponse(input logic gnt, input logic rvalid,
                                  input logic [31:0] rdata, input logic err);
    bus_if.bus_gnt_i    = gnt;
    bus_if.bus_rvalid_i = rvalid;
    bus_if.bus_rdata_i  = rdata;
    bus_if.bus_err_i    = err;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("rst_req",   {31'h0, bus_if.bus_req_o}, 32'h0);
    checkOutput("rst_we",    {31'h0, bus_if.bus_we_o},  32'h0);
    checkOutput("rst_be",    {28'h0, bus_if.bus_be_o},  32'h0);
    checkOutput("rst_addr",  bus_if.bus_addr_o,         32'h0);
    checkOutput("rst_wdata", bus_if.bus_wdata_o,        32'h0);
    checkOutput("rst_done",  {31'h0, lsu_done_o},       32'h0);
    checkOutput("rst_rd",    lsu_rd_data_o,             32'h0);
    checkOutput("rst_flags", {30'h0, lsu_misaligned_o, lsu_err_o}, 32'h0);
    reset_n = 1'b1;

    // SB 0x2003, immediate grant and response: done in cycle 3
    tick();
    applyStimulus(1'b1, 1'b1, 32'h2003, 32'h000000A5, 2'b00, 1'b0);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("sb_c0_stall", {31'h0, lsu_stall_o},       32'h1);
    checkOutput("sb_c0_req",   {31'h0, bus_if.bus_req_o},  32'h0);
    tick(); #1;
    checkOutput("sb_c1_req",   {31'h0, bus_if.bus_req_o},  32'h1);
    checkOutput("sb_c1_be",    {28'h0, bus_if.bus_be_o},   32'h8);
    checkOutput("sb_c1_wdata", bus_if.bus_wdata_o,         32'hA5A5A5A5);
    checkOutput("sb_c1_we",    {31'h0, bus_if.bus_we_o},   32'h1);
    checkOutput("sb_c1_addr",  bus_if.bus_addr_o,          32'h00002000);
    tick();
    applyBusResponse(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    #1;
    checkOutput("sb_c2_req",   {31'h0, bus_if.bus_req_o},  32'h0);
    checkOutput("sb_c2_done",  {31'h0, lsu_done_o},        32'h0);
    checkOutput("sb_c2_stall", {31'h0, lsu_stall_o},       32'h1);
    tick(); #1;
    checkOutput("sb_c3_done",  {31'h0, lsu_done_o},        32'h1);
    checkOutput("sb_c3_rd",    lsu_rd_data_o,              32'h0);
    checkOutput("sb_c3_err",   {31'h0, lsu_err_o},         32'h0);
    checkOutput("sb_c3_stall", {31'h0, lsu_stall_o},       32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("sb_c4_done",  {31'h0, lsu_done_o},        32'h0);

    // LH 0x2002 sign-extended
    applyStimulus(1'b1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b0);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("lh_be",   {28'h0, bus_if.bus_be_o},  32'hC);
    checkOutput("lh_we",   {31'h0, bus_if.bus_we_o},  32'h0);
    tick();
    applyBusResponse(1'b1, 1'b1, 32'h80011234, 1'b0);
    tick(); #1;
    checkOutput("lh_done", {31'h0, lsu_done_o}, 32'h1);
    checkOutput("lh_rd",   lsu_rd_data_o,       32'hFFFF8001);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // LHU, same access zero-extended
    applyStimulus(1'b1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b1);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    applyBusResponse(1'b1, 1'b1, 32'h80011234, 1'b0);
    tick(); #1;
    checkOutput("lhu_done", {31'h0, lsu_done_o}, 32'h1);
    checkOutput("lhu_rd",   lsu_rd_data_o,       32'h00008001);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // LW 0x2001 misaligned: done in cycle 1, no bus request
    applyStimulus(1'b1, 1'b0, 32'h2001, 32'h0, 2'b10, 1'b0);
    #1;
    checkOutput("mis_c0_req",  {31'h0, bus_if.bus_req_o}, 32'h0);
    tick(); #1;
    checkOutput("mis_c1_done", {31'h0, lsu_done_o},       32'h1);
    checkOutput("mis_c1_flag", {31'h0, lsu_misaligned_o}, 32'h1);
    checkOutput("mis_c1_rd",   lsu_rd_data_o,             32'h0);
    checkOutput("mis_c1_req",  {31'h0, bus_if.bus_req_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick(); #1;
    checkOutput("mis_c2_req",  {31'h0, bus_if.bus_req_o}, 32'h0);
    checkOutput("mis_c2_done", {31'h0, lsu_done_o},       32'h0);

    // LW 0x3000 with grant held low 5 cycles, response 3 cycles after grant
    applyStimulus(1'b1, 1'b0, 32'h3000, 32'h0, 2'b10, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(); #1;
      checkOutput($sformatf("gnt_c%0d_req", i),   {31'h0, bus_if.bus_req_o}, 32'h1);
      checkOutput($sformatf("gnt_c%0d_addr", i),  bus_if.bus_addr_o,         32'h00003000);
      checkOutput($sformatf("gnt_c%0d_be", i),    {28'h0, bus_if.bus_be_o},  32'hF);
      checkOutput($sformatf("gnt_c%0d_stall", i), {31'h0, lsu_stall_o},      32'h1);
    end
    tick();
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("gnt_c6_req", {31'h0, bus_if.bus_req_o}, 32'h1);
    for (int i = 7; i <= 8; i++) begin
      tick();
      applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput($sformatf("gnt_c%0d_req", i),   {31'h0, bus_if.bus_req_o}, 32'h0);
      checkOutput($sformatf("gnt_c%0d_stall", i), {31'h0, lsu_stall_o},      32'h1);
      checkOutput($sformatf("gnt_c%0d_done", i),  {31'h0, lsu_done_o},       32'h0);
    end
    tick();
    applyBusResponse(1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    #1;
    checkOutput("gnt_c9_stall", {31'h0, lsu_stall_o}, 32'h1);
    checkOutput("gnt_c9_done",  {31'h0, lsu_done_o},  32'h0);
    tick(); #1;
    checkOutput("gnt_c10_done", {31'h0, lsu_done_o},  32'h1);
    checkOutput("gnt_c10_rd",   lsu_rd_data_o,        32'hDEADBEEF);
    checkOutput("gnt_c10_err",  {31'h0, lsu_err_o},   32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // LB 0x2001 with no response: timeout 5 cycles after entering WAIT
    applyStimulus(1'b1, 1'b0, 32'h2001, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("to_be", {28'h0, bus_if.bus_be_o}, 32'h2);
    for (int i = 2; i <= 6; i++) begin
      tick(); #1;
      checkOutput($sformatf("to_c%0d_done", i),  {31'h0, lsu_done_o},  32'h0);
      checkOutput($sformatf("to_c%0d_stall", i), {31'h0, lsu_stall_o}, 32'h1);
    end
    tick(); #1;
    checkOutput("to_c7_done", {31'h0, lsu_done_o}, 32'h1);
    checkOutput("to_c7_err",  {31'h0, lsu_err_o},  32'h1);
    checkOutput("to_c7_rd",   lsu_rd_data_o,       32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    applyBusResponse(1'b0, 1'b1, 32'h12345678, 1'b0);
    tick();
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("to_late_done", {31'h0, lsu_done_o},       32'h0);
    checkOutput("to_late_req",  {31'h0, bus_if.bus_req_o}, 32'h0);

    // SH 0x2002 interrupted by reset while in WAIT
    applyStimulus(1'b1, 1'b1, 32'h2002, 32'h00001234, 2'b01, 1'b0);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("rw_be",    {28'h0, bus_if.bus_be_o}, 32'hC);
    checkOutput("rw_wdata", bus_if.bus_wdata_o,       32'h12341234);
    tick();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    checkOutput("rw_req",   {31'h0, bus_if.bus_req_o}, 32'h0);
    checkOutput("rw_stall", {31'h0, lsu_stall_o},      32'h0);
    checkOutput("rw_be0",   {28'h0, bus_if.bus_be_o},  32'h0);
    tick();
    reset_n = 1'b1;
    applyBusResponse(1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rw_stale_done", {31'h0, lsu_done_o}, 32'h0);

    // SW 0x2004 after the reset completes normally
    applyStimulus(1'b1, 1'b1, 32'h2004, 32'hCAFEF00D, 2'b10, 1'b0);
    applyBusResponse(1'b1, 1'b0, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("sw_req",   {31'h0, bus_if.bus_req_o}, 32'h1);
    checkOutput("sw_addr",  bus_if.bus_addr_o,         32'h00002004);
    checkOutput("sw_be",    {28'h0, bus_if.bus_be_o},  32'hF);
    checkOutput("sw_wdata", bus_if.bus_wdata_o,        32'hCAFEF00D);
    tick();
    applyBusResponse(1'b1, 1'b1, 32'h0, 1'b0);
    tick(); #1;
    checkOutput("sw_done", {31'h0, lsu_done_o}, 32'h1);
    checkOutput("sw_err",  {31'h0, lsu_err_o},  32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    applyBusResponse(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and an external data bus with request/grant/response handshake. It replaces direct single-cycle data memory access. Per load/store it aligns write data to byte lanes, generates byte enables, runs the bus handshake, and right-aligns and extends read data. It stalls the core until the access completes, and flags misaligned, bus-error and timeout conditions.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT without bus_rvalid_i before the access is aborted with an error.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- lsu_req_i  in  1  load/store request. Held high, with all lsu_* inputs stable, while lsu_stall_o is high.
- lsu_wr_i  in  1  1 = store, 0 = load.
- lsu_addr_i  in  32  byte address (ALU result).
- lsu_wr_data_i  in  32  store data (rs2); low bits are significant.
- lsu_size_i  in  2  access size: BYTE=00, HALF=01, WORD=10; 11 behaves as WORD.
- lsu_zero_extnd_i  in  1  1 = zero-extend loads, 0 = sign-extend.
- lsu_stall_o  out  1  freezes PC and register-file writes.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_rd_data_o  out  32  extended load data, valid with lsu_done_o.
- lsu_misaligned_o  out  1  valid with lsu_done_o.
- lsu_err_o  out  1  bus error or timeout, valid with lsu_done_o.
- bus_req_o  out  1  bus request.
- bus_addr_o  out  32  word address; {lsu_addr_i[31:2],2'b00}.
- bus_we_o  out  1  write enable.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated write data.
- bus_gnt_i  in  1  grant; accepts the request in the cycle it is high together with bus_req_o.
- bus_rvalid_i  in  1  response valid, for both reads and writes.
- bus_rdata_i  in  32  read data, valid with bus_rvalid_i.
- bus_err_i  in  1  error, valid with bus_rvalid_i.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on lsu_req_i, evaluate alignment.
  - Misaligned when HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - Misaligned → DONE with misaligned=1, rd_data=0. No bus activity.
  - Aligned → REQ, registering bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o.
- REQ: bus_req_o=1 with stable outputs. bus_gnt_i=1 → WAIT, dropping req the next cycle. bus_rvalid_i here is ignored.
- WAIT: timeout counter starts at 0 on entry and increments each cycle.
  - bus_rvalid_i=1 → DONE, capturing extended data (loads only; stores give 0) and err=bus_err_i.
  - Counter reaches TIMEOUT_CYCLES first → DONE with err=1, rd_data=0.
- DONE: done=1 for one cycle, then → IDLE unconditionally.
  - The core advances at the end of the DONE cycle.
  - lsu_req_i seen in the following IDLE belongs to the next instruction.
- Byte enables:
  - BYTE: 0001<<addr[1:0].
  - HALF: 0011<<addr[1:0].
  - WORD: 1111.
- Write data replication:
  - BYTE: {4{wd[7:0]}}.
  - HALF: {2{wd[15:0]}}.
  - WORD: wd.
- Read data: shift bus_rdata_i right by addr[1:0]*8, then sign/zero-extend from bit 7 (BYTE) or bit 15 (HALF). WORD is unchanged.
- Stale responses: bus_rvalid_i in IDLE or DONE is ignored, including late responses after a timeout or a reset.

## Timing
- Reset: state=IDLE, counter=0. bus_req_o, bus_we_o, lsu_done_o, lsu_misaligned_o and lsu_err_o are 0. bus_be_o, bus_addr_o, bus_wdata_o and lsu_rd_data_o are 0.
- All outputs are registered except lsu_stall_o = lsu_req_i & (state≠DONE), which is combinational.
- Minimum aligned latency (gnt in the first REQ cycle, rvalid in the first WAIT cycle): request in cycle 0, bus_req_o in cycle 1, done in cycle 3. Stall covers cycles 0-2.
- Misaligned access: done in cycle 1.
- Timeout access: done exactly TIMEOUT_CYCLES+1 cycles after entering WAIT.
- Reset mid-access: immediate return to IDLE with bus_req_o=0. The outstanding transaction is abandoned.
- No pipelining: at most one bus transaction is outstanding.

## Structure
- In yarp_pkg:
  - lsu_size_t: BYTE, HALF, WORD.
  - lsu_state_t: IDLE, REQ, WAIT, DONE.
- Sub-module lsu_align: combinational. Computes byte enables, write-data replication, read shift/extension and the misaligned flag. It is instantiated in load_store_unit alongside the FSM and the timeout counter.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- SB: addr 0x2003, wd 0x000000A5 → bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, bus_we_o=1; done 3 cycles after req with gnt and rvalid immediate.
- LH sign-extended: addr 0x2002, bus_rdata_i=0x8001_1234 → lsu_rd_data_o=0xFFFF8001. The same access with LHU → 0x00008001.
- LW at 0x2001 → done in cycle 1 with misaligned=1, and bus_req_o never asserts.
- Grant held low 5 cycles and rvalid after 3 more → req stays high with stable addr/be through REQ; done 1 cycle after rvalid; stall high throughout.
- TIMEOUT_CYCLES=4, no rvalid → err=1 with done exactly 5 cycles after entering WAIT. A late rvalid 2 cycles later is ignored.
- reset_n low while in WAIT → bus_req_o and stall drop, state IDLE. A subsequent SW completes normally.
